// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// divider sequencer states and the stall-counter width.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_stall_ctrl_div_seq.sv
// Divider occupancy sequencer: tracks how long a DIV/DIVU holds EX and
// flags when its result is ready to be captured.
module div_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_start_i,
  input  logic       mem_stall_i,
  output div_state_e state_o,
  output logic       div_busy_o,
  output logic       div_ready_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic            div_busy_q, div_busy_d;
  logic            div_ready_q, div_ready_d;

  // busy/ready are computed alongside the next state so they come straight from flops
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    div_busy_d  = div_busy_q;
    div_ready_d = div_ready_q;
    case (state_q)
      RUN: begin
        if (div_start_i) begin
          state_d    = DIV_BUSY;
          div_cnt_d  = CW'(DIV_CYCLES - 1);
          div_busy_d = 1'b1;
        end else begin
          div_busy_d  = 1'b0;
          div_ready_d = 1'b0;
        end
      end
      DIV_BUSY: begin
        if (div_cnt_q == {CW{1'b0}}) begin
          state_d     = DIV_DONE;
          div_busy_d  = 1'b0;
          div_ready_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q - CW'(1);
        end
      end
      DIV_DONE: begin
        // div_start_i here is the finished divide itself, so it is not a new start
        if (!mem_stall_i) begin
          state_d     = RUN;
          div_ready_d = 1'b0;
        end else begin
          div_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = RUN;
        div_cnt_d   = {CW{1'b0}};
        div_busy_d  = 1'b0;
        div_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      div_cnt_q   <= {CW{1'b0}};
      div_busy_q  <= 1'b0;
      div_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      div_busy_q  <= div_busy_d;
      div_ready_q <= div_ready_d;
    end
  end

  assign state_o     = state_q;
  assign div_busy_o  = div_busy_q;
  assign div_ready_o = div_ready_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges memory wait,
// divide occupancy, load-use and taken-branch events into one control vector.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lu_hazard_i,
  input  logic                   div_start_i,
  input  logic                   branch_taken_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ack_i,
  output logic                   en_pc_o,
  output logic                   en_fd_o,
  output logic                   en_de_o,
  output logic                   en_em_o,
  output logic                   en_mw_o,
  output logic                   flush_fd_o,
  output logic                   flush_de_o,
  output logic                   flush_em_o,
  output logic                   flush_mw_o,
  output logic                   div_busy_o,
  output logic                   div_ready_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  div_state_e             div_state_s;
  logic                   mem_stall_s;
  logic                   div_stall_s;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  assign mem_stall_s = dmem_req_i & ~dmem_ack_i;
  assign div_stall_s = ((div_state_s == RUN) & div_start_i) | (div_state_s == DIV_BUSY);

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .div_start_i(div_start_i),
    .mem_stall_i(mem_stall_s),
    .state_o    (div_state_s),
    .div_busy_o (div_busy_o),
    .div_ready_o(div_ready_o)
  );

  // Older hazards win; a blocked branch stays asserted by ID and is re-evaluated later
  always_comb begin
    en_pc_o    = 1'b1;
    en_fd_o    = 1'b1;
    en_de_o    = 1'b1;
    en_em_o    = 1'b1;
    en_mw_o    = 1'b1;
    flush_fd_o = 1'b0;
    flush_de_o = 1'b0;
    flush_em_o = 1'b0;
    flush_mw_o = 1'b0;
    if (rst) begin
      en_pc_o    = 1'b0;
      en_fd_o    = 1'b0;
      en_de_o    = 1'b0;
      en_em_o    = 1'b0;
      en_mw_o    = 1'b0;
      flush_fd_o = 1'b1;
      flush_de_o = 1'b1;
      flush_em_o = 1'b1;
      flush_mw_o = 1'b1;
    end else if (mem_stall_s) begin
      en_pc_o    = 1'b0;
      en_fd_o    = 1'b0;
      en_de_o    = 1'b0;
      en_em_o    = 1'b0;
      flush_mw_o = 1'b1;
    end else if (div_stall_s) begin
      en_pc_o    = 1'b0;
      en_fd_o    = 1'b0;
      en_de_o    = 1'b0;
      flush_em_o = 1'b1;
    end else if (lu_hazard_i) begin
      en_pc_o    = 1'b0;
      en_fd_o    = 1'b0;
      flush_de_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_fd_o = 1'b1;
    end else begin
      flush_fd_o = 1'b0;
    end
  end

  always_comb begin
    if (!en_pc_o && (stall_cycles_q != {STALL_CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with DIV_CYCLES=32.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lu_hazard_i, div_start_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic        en_pc_o, en_fd_o, en_de_o, en_em_o, en_mw_o;
  logic        flush_fd_o, flush_de_o, flush_em_o, flush_mw_o;
  logic        div_busy_o, div_ready_o;
  logic [31:0] stall_cycles_o;
  logic [8:0]  ctrl_s;

  int n_checks = 0;
  int n_errors = 0;

  // {en_pc,en_fd,en_de,en_em,en_mw, flush_fd,flush_de,flush_em,flush_mw}
  localparam logic [8:0] V_IDLE = 9'b11111_0000;
  localparam logic [8:0] V_RST  = 9'b00000_1111;
  localparam logic [8:0] V_MEM  = 9'b00001_0001;
  localparam logic [8:0] V_DIV  = 9'b00011_0010;
  localparam logic [8:0] V_LU   = 9'b00111_0100;
  localparam logic [8:0] V_BR   = 9'b11111_1000;

  always #5 clk = ~clk;

  assign ctrl_s = {en_pc_o, en_fd_o, en_de_o, en_em_o, en_mw_o,
                   flush_fd_o, flush_de_o, flush_em_o, flush_mw_o};

  pipe_stall_ctrl #(.DIV_CYCLES(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .lu_hazard_i   (lu_hazard_i),
    .div_start_i   (div_start_i),
    .branch_taken_i(branch_taken_i),
    .dmem_req_i    (dmem_req_i),
    .dmem_ack_i    (dmem_ack_i),
    .en_pc_o       (en_pc_o),
    .en_fd_o       (en_fd_o),
    .en_de_o       (en_de_o),
    .en_em_o       (en_em_o),
    .en_mw_o       (en_mw_o),
    .flush_fd_o    (flush_fd_o),
    .flush_de_o    (flush_de_o),
    .flush_em_o    (flush_em_o),
    .flush_mw_o    (flush_mw_o),
    .div_busy_o    (div_busy_o),
    .div_ready_o   (div_ready_o),
    .stall_cycles_o(stall_cycles_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle
  task automatic step(input logic r, input logic lu, input logic ds, input logic br,
                      input logic rq, input logic ak);
    @(negedge clk);
    rst = r; lu_hazard_i = lu; div_start_i = ds; branch_taken_i = br;
    dmem_req_i = rq; dmem_ack_i = ak;
    #1;
  endtask

  initial begin
    rst = 1'b1; lu_hazard_i = 1'b0; div_start_i = 1'b0; branch_taken_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;

    // Reset held two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_ctrl", 32'(ctrl_s), 32'(V_RST));
    end
    chk("rst_stall", stall_cycles_o, 32'd0);
    chk("rst_busy", 32'(div_busy_o), 32'd0);
    chk("rst_ready", 32'(div_ready_o), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_ctrl", 32'(ctrl_s), 32'(V_IDLE));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_stall", stall_cycles_o, 32'd0);

    // Load-use: one cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_ctrl", 32'(ctrl_s), 32'(V_LU));
    chk("lu_stall_before", stall_cycles_o, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_after", stall_cycles_o, 32'd1);
    chk("lu_release_ctrl", 32'(ctrl_s), 32'(V_IDLE));

    // Branch together with load-use, then branch alone
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_lu_ctrl", 32'(ctrl_s), 32'(V_LU));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_only_ctrl", 32'(ctrl_s), 32'(V_BR));
    chk("br_stall", stall_cycles_o, 32'd2);

    // Plain divide from a fresh counter
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 34; c++) begin
      step(1'b0, 1'b0, (c <= 33) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("div_ctrl_c%0d", c), 32'(ctrl_s), (c <= 32) ? 32'(V_DIV) : 32'(V_IDLE));
      chk($sformatf("div_busy_c%0d", c), 32'(div_busy_o), (c >= 1 && c <= 32) ? 32'd1 : 32'd0);
      chk($sformatf("div_ready_c%0d", c), 32'(div_ready_o), (c == 33) ? 32'd1 : 32'd0);
      if (c >= 33) chk($sformatf("div_stall_c%0d", c), stall_cycles_o, 32'd33);
    end

    // Memory wait starting at divide cycle 5, ack 40 cycles later
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 46; c++) begin
      step(1'b0, 1'b0, (c <= 45) ? 1'b1 : 1'b0, 1'b0,
           (c >= 5 && c <= 45) ? 1'b1 : 1'b0, (c == 45) ? 1'b1 : 1'b0);
      chk($sformatf("mdiv_ctrl_c%0d", c), 32'(ctrl_s),
          (c < 5) ? 32'(V_DIV) : (c <= 44) ? 32'(V_MEM) : 32'(V_IDLE));
      chk($sformatf("mdiv_busy_c%0d", c), 32'(div_busy_o), (c >= 1 && c <= 32) ? 32'd1 : 32'd0);
      chk($sformatf("mdiv_ready_c%0d", c), 32'(div_ready_o), (c >= 33 && c <= 45) ? 32'd1 : 32'd0);
    end
    chk("mdiv_stall", stall_cycles_o, 32'd45);

    // Saturation of the stall counter
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_preload", stall_cycles_o, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_step1", stall_cycles_o, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", stall_cycles_o, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and synchronous-clear inputs of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, multi-cycle divide occupancy of EX, data-memory wait states and taken-branch squashes into one consistent per-cycle control vector. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- DIV_CYCLES, 32, number of iteration cycles the divider needs after its start cycle; legal range 1..255.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- lu_hazard_i  in  1  ID instruction reads the destination of a load currently in EX
- div_start_i  in  1  EX stage holds a DIV/DIVU; held high for as long as that instruction remains in EX
- branch_taken_i  in  1  branch/jump resolved taken in ID this cycle
- dmem_req_i  in  1  MEM stage has an outstanding data access
- dmem_ack_i  in  1  data memory completes the access this cycle
- en_pc_o, en_fd_o, en_de_o, en_em_o, en_mw_o  out  1 each  register load enables
- flush_fd_o, flush_de_o, flush_em_o, flush_mw_o  out  1 each  synchronous clear of the register after the named boundary; the register clears whenever flush is 1, regardless of its enable
- div_busy_o  out  1  divider iterating
- div_ready_o  out  1  divider result valid; EX captures the result this cycle
- stall_cycles_o  out  32  saturating count of cycles with en_pc_o=0

## Operation
- State machine: RUN, DIV_BUSY, DIV_DONE. There is also a counter div_cnt, $clog2(DIV_CYCLES+1) bits wide.
- RUN with div_start_i=1: load div_cnt=DIV_CYCLES-1 and go to DIV_BUSY.
- DIV_BUSY: decrement div_cnt every cycle, regardless of memory stalls. When div_cnt==0, go to DIV_DONE.
- DIV_DONE: div_ready_o=1.
  - If mem_stall=0, go to RUN. div_start_i is ignored in this cycle, because it is the same instruction leaving EX.
  - If mem_stall=1, hold DIV_DONE with div_ready_o kept at 1.
- div_busy_o is 1 only in DIV_BUSY.
- Derived conditions:
  - mem_stall = dmem_req_i & ~dmem_ack_i
  - div_stall = (RUN & div_start_i) | DIV_BUSY
- Control vector, highest priority first. All signals not listed are en=1, flush=0.
  - mem_stall: en_pc=en_fd=en_de=en_em=0; en_mw=1, flush_mw=1.
  - div_stall: en_pc=en_fd=en_de=0; en_em=1, flush_em=1.
  - lu_hazard_i: en_pc=en_fd=0; flush_de=1.
  - branch_taken_i: flush_fd=1. This applies only when none of the above conditions is active; otherwise the branch is held and re-evaluated.
- rst=1 forces the following, overriding all inputs:
  - all en_*=0 and all flush_*=1
  - state=RUN, div_cnt=0, div_busy_o=0, div_ready_o=0, stall_cycles_o=0
- stall_cycles_o increments when rst=0 and en_pc_o=0, and saturates at 32'hFFFF_FFFF.

## Timing
- All outputs except stall_cycles_o are combinational from the registered state and the current inputs. There are no registered control outputs.
- Divide with DIV_CYCLES=N and no memory stall:
  - T0: RUN & div_start_i, stall.
  - T1..TN: DIV_BUSY, stall.
  - TN+1: DIV_DONE, en_de=1, div_ready_o=1.
  - TN+2: RUN.
  - Total stall is N+1 cycles.
- A load-use stall costs exactly 1 cycle, because the load leaves EX the next cycle and lu_hazard_i drops.
- mem_stall during DIV_BUSY: div_cnt keeps counting; the memory control vector takes priority.
- Simultaneous events: lu_hazard_i and branch_taken_i together produce a load-use stall only, with no flush_fd.
- Reset mid-divide: state returns to RUN on the next edge. The divider datapath is cleared by its own rst.

## Structure
- State encodings (RUN=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2) and the stall-counter width go in the shared cpu_defs include.
- One sub-module, div_seq, owns the FSM, div_cnt, div_busy_o and div_ready_o.
- The priority encoder producing the control vector and the perf counter stay in the top level.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all en_*=0, all flush_*=1, stall_cycles_o=0; after release with idle inputs, all en_*=1 and all flush_*=0.
- Load-use: lu_hazard_i=1 for 1 cycle -> en_pc=en_fd=0, flush_de=1 that cycle; stall_cycles_o goes 0->1.
- Divide, DIV_CYCLES=32: div_start_i held until div_ready_o -> div_busy_o=1 for exactly 32 cycles; div_ready_o=1 at cycle 33 after start; flush_em=1 for cycles 0..32; stall_cycles_o=33.
- Memory wait inside divide: dmem_req_i=1 with ack delayed 40 cycles, starting at divide cycle 5 -> DIV_DONE is held with div_ready_o=1 until ack; flush_mw=1 throughout the wait; RUN on the cycle after ack.
- Branch priority: branch_taken_i=1 together with lu_hazard_i=1 -> flush_fd=0; on the next cycle with branch_taken_i only -> flush_fd=1, en_pc=1.
- Saturation: force the counter to 32'hFFFF_FFFE and stall 3 cycles -> stall_cycles_o=32'hFFFF_FFFF.
